// File: rtl/opendap_swd_dormant_sequencer.sv
// ---------------------------------------------------------------------------
// opendap_swd_dormant_sequencer
//
// Purpose:
//   Generates the SWDIO bit streams that move an SWD target between its
//   dormant and SWD states, and plain line resets. It handles three kinds of
//   sequence:
//     - line reset : RESET_HIGH_CYCLES ones, then two zeros
//     - wake       : WAKE_HIGH_CYCLES ones, the 128-bit selection alert,
//                    four zeros, the SWD activation code 8'b01011000 (MSB
//                    first), then a line reset
//     - sleep      : RESET_HIGH_CYCLES ones, then 16'b0011110111000111
//                    (MSB first)
//   A bit is consumed only on cycles where bit_en is high. All outputs are
//   registered, and they change only after a consumed bit.
//
// Configuration:
//   OPENDAP_DORMANT_SEQ_SLEEP_EN - when defined, cmd 2'b10 runs the
//   SWD-to-dormant sleep sequence. When undefined, cmd 2'b10 runs a line
//   reset and the S2D_SELECT logic is not built.
//
// Parameters:
//   RESET_HIGH_CYCLES - ones in each line reset (50..63)
//   WAKE_HIGH_CYCLES  - ones before the selection alert (8..63)
//
// Ports:
//   clk       in   host logic clock, all state on posedge
//   rst       in   asynchronous active-high reset
//   cmd_valid in   command request
//   cmd_ready out  sequencer idle; a command is accepted on cmd_valid && cmd_ready
//   cmd[1:0]  in   00/11 line reset, 01 wake, 10 sleep
//   bit_en    in   SWCLK tick; the current swdo bit goes to the target this cycle
//   swdo      out  SWDIO data
//   swdo_oe   out  SWDIO output enable
//   busy      out  sequence in progress
//   done      out  one-cycle pulse after the last bit is consumed
// ---------------------------------------------------------------------------
module opendap_swd_dormant_sequencer #(
  parameter int RESET_HIGH_CYCLES = 50,
  parameter int WAKE_HIGH_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       bit_en,
  output logic       swdo,
  output logic       swdo_oe,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    HIGH_PRE,
    ALERT,
    POST_ALERT,
    SELECT,
    RST_HIGH,
    RST_LOW,
    S2D_SELECT
  } state_t;

  localparam logic [6:0] LFSR_INIT      = 7'b1001001;
  localparam logic [6:0] LFSR_TAPS      = 7'b1001011;
  localparam logic [7:0] SELECT_PATTERN = 8'b01011000;
  localparam logic [6:0] RST_HIGH_LAST  = 7'(RESET_HIGH_CYCLES - 1);
  localparam logic [6:0] WAKE_LAST      = 7'(WAKE_HIGH_CYCLES - 1);
  localparam logic [6:0] ALERT_LAST     = 7'd127;
  localparam logic [6:0] POST_LAST      = 7'd3;
  localparam logic [6:0] SELECT_LAST    = 7'd7;
  localparam logic [6:0] RST_LOW_LAST   = 7'd1;
`ifdef OPENDAP_DORMANT_SEQ_SLEEP_EN
  localparam logic [15:0] SLEEP_PATTERN = 16'b0011110111000111;
  localparam logic [6:0]  SLEEP_LAST    = 7'd15;
`endif

  state_t     state, state_next;
  logic [6:0] cnt, cnt_next;
  logic [6:0] lfsr, lfsr_next;
  logic       swdo_next;
`ifdef OPENDAP_DORMANT_SEQ_SLEEP_EN
  // Records whether the running RST_HIGH field belongs to a sleep sequence.
  // This chooses whether RST_HIGH is followed by RST_LOW or by S2D_SELECT.
  logic       sleep_seq, sleep_seq_next;
`endif

  assign cmd_ready = (state == IDLE);

  // State, field counter and alert LFSR. The outputs are registered from the
  // next-state values, so swdo always shows the bit for the field and index
  // that the state register holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 7'd0;
      lfsr    <= LFSR_INIT;
      swdo    <= 1'b1;
      swdo_oe <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef OPENDAP_DORMANT_SEQ_SLEEP_EN
      sleep_seq <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      lfsr    <= lfsr_next;
      swdo    <= swdo_next;
      swdo_oe <= (state_next != IDLE);
      busy    <= (state_next != IDLE);
      done    <= (state != IDLE) && (state_next == IDLE);
`ifdef OPENDAP_DORMANT_SEQ_SLEEP_EN
      sleep_seq <= sleep_seq_next;
`endif
    end
  end

  // Next-state logic. Each field loads cnt with (length - 1) when it is
  // entered and counts down on consumed bits. The bit_en that consumes the
  // bit at cnt == 0 moves to the following field, so the counter never wraps.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    lfsr_next  = lfsr;
`ifdef OPENDAP_DORMANT_SEQ_SLEEP_EN
    sleep_seq_next = sleep_seq;
`endif
    if (state == IDLE) begin
      if (cmd_valid) begin
        case (cmd)
          2'b01: begin
            state_next = HIGH_PRE;
            cnt_next   = WAKE_LAST;
          end
`ifdef OPENDAP_DORMANT_SEQ_SLEEP_EN
          2'b10: begin
            state_next     = RST_HIGH;
            cnt_next       = RST_HIGH_LAST;
            sleep_seq_next = 1'b1;
          end
`endif
          default: begin
            state_next = RST_HIGH;
            cnt_next   = RST_HIGH_LAST;
`ifdef OPENDAP_DORMANT_SEQ_SLEEP_EN
            sleep_seq_next = 1'b0;
`endif
          end
        endcase
      end
    end else if (bit_en) begin
      // The first alert bit is a fixed 0 and does not come from the LFSR.
      // The LFSR advances only on the bits after that one.
      if ((state == ALERT) && (cnt != ALERT_LAST)) begin
        lfsr_next = {^(lfsr & LFSR_TAPS), lfsr[6:1]};
      end
      if (cnt != 7'd0) begin
        cnt_next = cnt - 7'd1;
      end else begin
        case (state)
          HIGH_PRE: begin
            state_next = ALERT;
            cnt_next   = ALERT_LAST;
            lfsr_next  = LFSR_INIT;
          end
          ALERT: begin
            state_next = POST_ALERT;
            cnt_next   = POST_LAST;
          end
          POST_ALERT: begin
            state_next = SELECT;
            cnt_next   = SELECT_LAST;
          end
          SELECT: begin
            state_next = RST_HIGH;
            cnt_next   = RST_HIGH_LAST;
          end
          RST_HIGH: begin
`ifdef OPENDAP_DORMANT_SEQ_SLEEP_EN
            if (sleep_seq) begin
              state_next = S2D_SELECT;
              cnt_next   = SLEEP_LAST;
            end else begin
              state_next = RST_LOW;
              cnt_next   = RST_LOW_LAST;
            end
`else
            state_next = RST_LOW;
            cnt_next   = RST_LOW_LAST;
`endif
          end
          default: begin
            state_next = IDLE;
            cnt_next   = 7'd0;
          end
        endcase
      end
    end
  end

  // Bit value for the field and index that the state register will hold
  // next. This is what swdo presents until that bit is consumed.
  always_comb begin
    swdo_next = 1'b1;
    case (state_next)
      HIGH_PRE, RST_HIGH: swdo_next = 1'b1;
      ALERT:              swdo_next = (cnt_next == ALERT_LAST) ? 1'b0 : lfsr_next[0];
      POST_ALERT,
      RST_LOW:            swdo_next = 1'b0;
      SELECT:             swdo_next = SELECT_PATTERN[cnt_next[2:0]];
`ifdef OPENDAP_DORMANT_SEQ_SLEEP_EN
      S2D_SELECT:         swdo_next = SLEEP_PATTERN[cnt_next[3:0]];
`endif
      default:            swdo_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_opendap_swd_dormant_sequencer.sv
// ---------------------------------------------------------------------------
// tb_opendap_swd_dormant_sequencer
//
// Self-checking bench for the dormant/line-reset sequencer. A reference model
// builds each expected bit stream directly from its field list: ones, the
// alert LFSR, the select code and the reset lows. The bench drives bit_en
// with random duty cycles, captures the bits the target would consume, and
// compares them with the model.
// ---------------------------------------------------------------------------
module tb_opendap_swd_dormant_sequencer;

  localparam int RH         = 50;
  localparam int WH         = 8;
  localparam int MAX_CYCLES = 4000;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic       bit_en;
  logic       swdo;
  logic       swdo_oe;
  logic       busy;
  logic       done;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Results of the most recent capture_stream call
  bit         got[$];
  bit         exp_q[$];
  logic [4:0] end_flags;
  bit         last_en;
  int         unstable;
  bit         timeout;
  logic       first_busy;

  opendap_swd_dormant_sequencer #(
    .RESET_HIGH_CYCLES(RH),
    .WAKE_HIGH_CYCLES (WH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd      (cmd),
    .bit_en   (bit_en),
    .swdo     (swdo),
    .swdo_oe  (swdo_oe),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Watchdog: stops the run if any sequence stalls
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference stream for one command, built from the field lengths
  task automatic model_stream(input logic [1:0] c);
    logic [6:0]  l;
    logic [7:0]  sel;
    logic [15:0] slp;
    bit          sleep_en;
`ifdef OPENDAP_DORMANT_SEQ_SLEEP_EN
    sleep_en = 1'b1;
`else
    sleep_en = 1'b0;
`endif
    exp_q.delete();
    sel = 8'b01011000;
    slp = 16'b0011110111000111;
    if (c == 2'b01) begin
      repeat (WH) exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      l = 7'b1001001;
      for (int i = 0; i < 127; i++) begin
        exp_q.push_back(l[0]);
        l = {^(l & 7'b1001011), l[6:1]};
      end
      repeat (4) exp_q.push_back(1'b0);
      for (int i = 7; i >= 0; i--) exp_q.push_back(sel[i]);
      repeat (RH) exp_q.push_back(1'b1);
      repeat (2) exp_q.push_back(1'b0);
    end else if (c == 2'b10 && sleep_en) begin
      repeat (RH) exp_q.push_back(1'b1);
      for (int i = 15; i >= 0; i--) exp_q.push_back(slp[i]);
    end else begin
      repeat (RH) exp_q.push_back(1'b1);
      repeat (2) exp_q.push_back(1'b0);
    end
  endtask

  // Returns the first index where got and exp_q differ, or -1 if they match
  function automatic int stream_diff();
    int n;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
    if (got.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // Issues one command, then drives random bit_en until done or busy drops.
  // Records every bit sampled on a bit_en cycle with swdo_oe high.
  // Must be called at a negedge with the DUT idle.
  task automatic capture_stream(input logic [1:0] c, input int duty, input bit noise);
    int   cycles;
    logic prev_swdo;
    logic prev_oe;
    logic prev_en;
    bit   first;
    cycles    = 0;
    prev_swdo = 1'b1;
    prev_oe   = 1'b0;
    prev_en   = 1'b0;
    first     = 1'b1;
    got.delete();
    end_flags  = '0;
    last_en    = 1'b0;
    unstable   = 0;
    timeout    = 1'b0;
    first_busy = 1'b0;
    cmd       = c;
    cmd_valid = 1'b1;
    bit_en    = 1'($urandom_range(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    forever begin
      if (first) begin
        first_busy = busy;
        first      = 1'b0;
      end
      if (prev_oe && swdo_oe && !prev_en && (swdo !== prev_swdo)) unstable++;
      if (done || !busy) begin
        end_flags = {done, busy, swdo_oe, swdo, cmd_ready};
        last_en   = prev_en;
        break;
      end
      if (cycles >= MAX_CYCLES) begin
        timeout = 1'b1;
        break;
      end
      bit_en = ($urandom_range(99) < duty);
      if (noise) begin
        cmd_valid = 1'($urandom_range(1));
        cmd       = 2'($urandom_range(3));
      end
      if (bit_en && swdo_oe) got.push_back(swdo);
      prev_swdo = swdo;
      prev_oe   = swdo_oe;
      prev_en   = bit_en;
      @(negedge clk);
      cycles++;
    end
    cmd_valid = 1'b0;
    bit_en    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; bit_en = 1'b0;
    repeat (3) @(negedge clk);
    n_compared++;
    if ({swdo, swdo_oe, busy, done, cmd_ready} !== 5'b10001) begin
      n_mismatched++;
      $display("[TB] FAIL reset_values: got %b required 10001 (swdo,oe,busy,done,ready)",
               {swdo, swdo_oe, busy, done, cmd_ready});
    end
    cmd_valid = 1'b1; bit_en = 1'b1;
    @(negedge clk);
    n_compared++;
    if ({busy, swdo_oe} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_holds_idle: busy/oe got %b required 00", {busy, swdo_oe});
    end
    cmd_valid = 1'b0; bit_en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_line_reset();
    int d;
    capture_stream(2'b00, 100, 1'b0);
    model_stream(2'b00);
    n_compared++;
    if (first_busy !== 1'b1 || timeout) begin
      n_mismatched++;
      $display("[TB] FAIL first_accept: busy after first edge got %b required 1 (timeout=%0d)",
               first_busy, timeout);
    end
    d = stream_diff();
    n_compared++;
    if (d !== -1 || got.size() !== 52) begin
      n_mismatched++;
      $display("[TB] FAIL line_reset_stream: %0d bits, first diff at %0d; required 52 bits, no diff",
               got.size(), d);
    end
    n_compared++;
    if (end_flags !== 5'b10011 || last_en !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL line_reset_done: flags %b last_en %b required 10011 / 1",
               end_flags, last_en);
    end
    @(negedge clk);
    n_compared++;
    if ({done, swdo_oe, swdo} !== 3'b001) begin
      n_mismatched++;
      $display("[TB] FAIL line_reset_after: done,oe,swdo got %b required 001", {done, swdo_oe, swdo});
    end
  endtask

  task automatic test_wake();
    int d;
    capture_stream(2'b01, 100, 1'b0);
    model_stream(2'b01);
    d = stream_diff();
    n_compared++;
    if (d !== -1 || got.size() !== 200 || timeout) begin
      n_mismatched++;
      $display("[TB] FAIL wake_stream: %0d bits, first diff at %0d; required 200 bits, no diff",
               got.size(), d);
    end
    n_compared++;
    if (got.size() < WH + 5) begin
      n_mismatched++;
      $display("[TB] FAIL wake_alert_head: stream too short (%0d bits) required >= %0d", got.size(), WH + 5);
    end else if ({got[WH], got[WH+1], got[WH+2], got[WH+3], got[WH+4]} !== 5'b01001) begin
      n_mismatched++;
      $display("[TB] FAIL wake_alert_head: got %b required 01001",
               {got[WH], got[WH+1], got[WH+2], got[WH+3], got[WH+4]});
    end
    n_compared++;
    if (end_flags !== 5'b10011 || last_en !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL wake_done: flags %b last_en %b required 10011 / 1", end_flags, last_en);
    end
  endtask

  task automatic test_sleep();
    int d;
    int exp_len;
`ifdef OPENDAP_DORMANT_SEQ_SLEEP_EN
    exp_len = 66;
`else
    exp_len = 52;
`endif
    @(negedge clk);
    capture_stream(2'b10, 100, 1'b0);
    model_stream(2'b10);
    d = stream_diff();
    n_compared++;
    if (d !== -1 || got.size() !== exp_len || timeout) begin
      n_mismatched++;
      $display("[TB] FAIL sleep_stream: %0d bits, first diff at %0d; required %0d bits, no diff",
               got.size(), d, exp_len);
    end
    n_compared++;
    if (end_flags !== 5'b10011) begin
      n_mismatched++;
      $display("[TB] FAIL sleep_done: flags %b required 10011", end_flags);
    end
  endtask

  task automatic test_wake_random_duty();
    int d;
    @(negedge clk);
    capture_stream(2'b01, 30, 1'b0);
    model_stream(2'b01);
    d = stream_diff();
    n_compared++;
    if (d !== -1 || timeout) begin
      n_mismatched++;
      $display("[TB] FAIL wake_duty30_stream: %0d bits, first diff at %0d, timeout %0d; required 200 bits",
               got.size(), d, timeout);
    end
    n_compared++;
    if (unstable !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL wake_duty30_stable: swdo changed on %0d idle ticks, required 0", unstable);
    end
    n_compared++;
    if (end_flags !== 5'b10011 || last_en !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL wake_duty30_done: flags %b last_en %b required 10011 / 1", end_flags, last_en);
    end
  endtask

  // Random commands and duty cycles, with cmd_valid/cmd toggled while busy
  task automatic test_random_cmds();
    int         d;
    logic [1:0] c;
    int         duty;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      c    = 2'($urandom_range(3));
      duty = int'($urandom_range(100, 20));
      capture_stream(c, duty, 1'b1);
      model_stream(c);
      d = stream_diff();
      n_compared++;
      if (d !== -1 || timeout || unstable !== 0) begin
        n_mismatched++;
        $display("[TB] FAIL random_cmd%0d (cmd=%b duty=%0d): %0d bits, diff at %0d, unstable %0d; required %0d bits",
                 k, c, duty, got.size(), d, unstable, exp_q.size());
      end
      n_compared++;
      if (end_flags !== 5'b10011) begin
        n_mismatched++;
        $display("[TB] FAIL random_cmd%0d_done: flags %b required 10011", k, end_flags);
      end
    end
  endtask

  task automatic test_abort();
    int consumed;
    int d;
    int done_seen;
    @(negedge clk);
    cmd = 2'b01; cmd_valid = 1'b1; bit_en = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    consumed = 0;
    while (consumed < 100 && busy) begin
      @(negedge clk);
      consumed++;
    end
    #2 rst = 1'b1;
    #1;
    n_compared++;
    if ({swdo_oe, busy, done, swdo} !== 4'b0001 || consumed !== 100) begin
      n_mismatched++;
      $display("[TB] FAIL abort_async: oe,busy,done,swdo got %b required 0001 (bits consumed %0d of 100)",
               {swdo_oe, busy, done, swdo}, consumed);
    end
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    n_compared++;
    if (done_seen !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_no_done: done/busy seen %0d cycles, required 0", done_seen);
    end
    capture_stream(2'b00, 100, 1'b0);
    model_stream(2'b00);
    d = stream_diff();
    n_compared++;
    if (d !== -1 || got.size() !== 52 || end_flags !== 5'b10011) begin
      n_mismatched++;
      $display("[TB] FAIL abort_then_reset: %0d bits, diff at %0d, flags %b; required 52 bits, 10011",
               got.size(), d, end_flags);
    end
  endtask

  // cmd_valid held high: two line resets, each followed by a single done/idle
  // cycle in which the next command is accepted
  task automatic test_back_to_back();
    logic [3:0] exp_v;
    int         pos;
    @(negedge clk);
    model_stream(2'b00);
    cmd = 2'b00; cmd_valid = 1'b1; bit_en = 1'b1;
    for (int k = 1; k <= 106; k++) begin
      @(negedge clk);
      pos = (k - 1) % 53;
      if (pos < 52) exp_v = {1'b1, 1'b1, exp_q[pos], 1'b0};
      else          exp_v = 4'b0011;
      n_compared++;
      if ({busy, swdo_oe, swdo, done} !== exp_v) begin
        n_mismatched++;
        $display("[TB] FAIL back_to_back cycle %0d: busy,oe,swdo,done got %b required %b",
                 k, {busy, swdo_oe, swdo, done}, exp_v);
      end
      if (k == 106) cmd_valid = 1'b0;
    end
    @(negedge clk);
    n_compared++;
    if ({busy, done} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL back_to_back_stop: busy,done got %b required 00", {busy, done});
    end
    bit_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_line_reset();
    test_wake();
    test_sleep();
    test_wake_random_duty();
    test_random_cmds();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
